du_exec_ctrl: RTL and testbench

Parametrised execution controller for the debug unit: generates the pipeline clock enable and CPU reset from host commands, supporting free run, N-cycle step, user pause, N_BP PC breakpoints and HALT detection. Sits between the debug unit's UART command decoder and PIPELINE (drives `i_clk_en` and ORs into `i_reset`), and replaces the fixed run/step clock-enable logic with a counted, breakpoint-aware controller.

---
 rtl/du_exec_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_du_exec_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/du_exec_ctrl.sv
// Debug-unit execution controller: gates the pipeline clock enable and CPU reset
// from host commands (run, counted step, pause, PC breakpoints, halt detection).
module du_exec_ctrl #(
    parameter int unsigned NB_PC   = 32,
    parameter int unsigned N_BP    = 4,
    parameter int unsigned NB_STEP = 16,
    parameter int unsigned RST_CYC = 4,
    localparam int unsigned NB_IDX = (N_BP > 1) ? $clog2(N_BP) : 1
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_cmd_valid,
    output logic               o_cmd_ready,
    input  logic [2:0]         i_cmd_op,
    input  logic [NB_IDX-1:0]  i_cmd_idx,
    input  logic [NB_PC-1:0]   i_cmd_arg,
    input  logic               i_halt,
    input  logic [NB_PC-1:0]   i_pc,
    output logic               o_clk_en,
    output logic               o_mips_reset,
    output logic [2:0]         o_state,
    output logic [1:0]         o_stop_cause,
    output logic               o_stop_valid,
    output logic               o_cmd_err,
    output logic [N_BP-1:0]    o_bp_en,
    output logic [NB_STEP-1:0] o_cycles
);
    localparam int unsigned    NB_RC   = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam logic [NB_RC-1:0] RC_LOAD = NB_RC'(RST_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_STEP  = 3'd2,
        S_DONE  = 3'd3,
        S_RESET = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        OP_NOP        = 3'd0,
        OP_RUN        = 3'd1,
        OP_STEP       = 3'd2,
        OP_PAUSE      = 3'd3,
        OP_SET_BP     = 3'd4,
        OP_CLR_BP     = 3'd5,
        OP_RESET_CPU  = 3'd6,
        OP_CLR_ALL_BP = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        C_PAUSE = 2'd0,
        C_STEP  = 2'd1,
        C_BP    = 2'd2,
        C_HALT  = 2'd3
    } cause_e;

    state_e             state, state_n;
    cause_e             cause, cause_n;
    op_e                op;
    logic [NB_STEP-1:0] step_cnt, step_cnt_n, step_load, cycles;
    logic [NB_RC-1:0]   rst_cnt, rst_cnt_n;
    logic               armed, armed_n;
    logic               stop_valid, stop_n, cmd_err, err_n;
    logic               cmd_fire, idx_ok, bp_hit, clk_en;
    logic [N_BP-1:0]    bp_en;
    logic [NB_PC-1:0]   bp_addr [N_BP];

    assign op          = op_e'(i_cmd_op);
    assign o_cmd_ready = (state != S_RESET);
    assign cmd_fire    = i_cmd_valid && o_cmd_ready;
    assign idx_ok      = 32'(i_cmd_idx) < N_BP;
    assign step_load   = (i_cmd_arg[NB_STEP-1:0] == '0) ? NB_STEP'(1) : i_cmd_arg[NB_STEP-1:0];

    always_comb begin
        bp_hit = 1'b0;
        for (int unsigned k = 0; k < N_BP; k++) begin
            if (bp_en[k] && (bp_addr[k] == i_pc)) bp_hit = 1'b1;
        end
    end

    always_comb begin
        state_n    = state;
        cause_n    = cause;
        step_cnt_n = step_cnt;
        rst_cnt_n  = rst_cnt;
        armed_n    = armed;
        stop_n     = 1'b0;
        err_n      = 1'b0;
        clk_en     = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd_fire) begin
                    case (op)
                        OP_RUN:       begin state_n = S_RUN;   armed_n    = 1'b0;      end
                        OP_STEP:      begin state_n = S_STEP;  step_cnt_n = step_load; end
                        OP_RESET_CPU: begin state_n = S_RESET; rst_cnt_n  = RC_LOAD;   end
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                // Disarmed on entry so a resume from the breakpoint PC executes first.
                clk_en = !i_halt && !(armed && bp_hit);
                if (clk_en) armed_n = 1'b1;
                if (i_halt) begin
                    state_n = S_DONE; cause_n = C_HALT; stop_n = 1'b1;
                end else if (armed && bp_hit) begin
                    state_n = S_IDLE; cause_n = C_BP; stop_n = 1'b1;
                end else if (cmd_fire && op == OP_PAUSE) begin
                    state_n = S_IDLE; cause_n = C_PAUSE; stop_n = 1'b1;
                end else if (cmd_fire && op == OP_RESET_CPU) begin
                    state_n = S_RESET; rst_cnt_n = RC_LOAD;
                end
                if (cmd_fire && (op == OP_RUN || op == OP_STEP)) err_n = 1'b1;
            end
            S_STEP: begin
                clk_en = !i_halt;
                if (clk_en) step_cnt_n = step_cnt - 1'b1;
                if (i_halt) begin
                    state_n = S_DONE; cause_n = C_HALT; stop_n = 1'b1;
                end else if (step_cnt == NB_STEP'(1)) begin
                    state_n = S_IDLE; cause_n = C_STEP; stop_n = 1'b1;
                end else if (cmd_fire && op == OP_PAUSE) begin
                    state_n = S_IDLE; cause_n = C_PAUSE; stop_n = 1'b1; step_cnt_n = '0;
                end else if (cmd_fire && op == OP_RESET_CPU) begin
                    state_n = S_RESET; rst_cnt_n = RC_LOAD;
                end
                if (cmd_fire && (op == OP_RUN || op == OP_STEP)) err_n = 1'b1;
            end
            S_DONE: begin
                if (cmd_fire && op == OP_RESET_CPU) begin
                    state_n = S_RESET; rst_cnt_n = RC_LOAD;
                end
                if (cmd_fire && (op == OP_RUN || op == OP_STEP || op == OP_PAUSE)) err_n = 1'b1;
            end
            S_RESET: begin
                if (rst_cnt == '0) state_n = S_IDLE;
                else               rst_cnt_n = rst_cnt - 1'b1;
            end
            default: state_n = S_IDLE;
        endcase
        if (cmd_fire && (op == OP_SET_BP || op == OP_CLR_BP) && !idx_ok) err_n = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= S_IDLE;
            cause      <= C_PAUSE;
            step_cnt   <= '0;
            rst_cnt    <= '0;
            armed      <= 1'b0;
            stop_valid <= 1'b0;
            cmd_err    <= 1'b0;
            cycles     <= '0;
            bp_en      <= '0;
            for (int unsigned k = 0; k < N_BP; k++) bp_addr[k] <= '0;
        end else begin
            state      <= state_n;
            cause      <= cause_n;
            step_cnt   <= step_cnt_n;
            rst_cnt    <= rst_cnt_n;
            armed      <= armed_n;
            stop_valid <= stop_n;
            cmd_err    <= err_n;
            if (state == S_RESET)              cycles <= '0;
            else if (clk_en && cycles != '1)   cycles <= cycles + 1'b1;
            if (cmd_fire && idx_ok) begin
                for (int unsigned k = 0; k < N_BP; k++) begin
                    if (NB_IDX'(k) == i_cmd_idx) begin
                        if (op == OP_SET_BP) begin
                            bp_en[k]   <= 1'b1;
                            bp_addr[k] <= i_cmd_arg;
                        end else if (op == OP_CLR_BP) begin
                            bp_en[k]   <= 1'b0;
                        end
                    end
                end
            end
            if (cmd_fire && op == OP_CLR_ALL_BP) bp_en <= '0;
        end
    end

    assign o_clk_en     = clk_en;
    assign o_mips_reset = (state == S_RESET);
    assign o_state      = state;
    assign o_stop_cause = cause;
    assign o_stop_valid = stop_valid;
    assign o_cmd_err    = cmd_err;
    assign o_bp_en      = bp_en;
    assign o_cycles     = cycles;

endmodule

// File: tb/tb_du_exec_ctrl.sv
// Directed bench for du_exec_ctrl: stimulus queues expected stop/error events,
// a negedge monitor pops and compares them whenever the DUT pulses.
module tb_du_exec_ctrl;
    localparam int unsigned NB_PC   = 32;
    localparam int unsigned N_BP    = 5;
    localparam int unsigned NB_STEP = 16;
    localparam int unsigned RST_CYC = 4;
    localparam int unsigned NB_IDX  = 3;

    logic               i_clk, i_reset, i_cmd_valid, o_cmd_ready, i_halt;
    logic [2:0]         i_cmd_op;
    logic [NB_IDX-1:0]  i_cmd_idx;
    logic [NB_PC-1:0]   i_cmd_arg, i_pc;
    logic               o_clk_en, o_mips_reset, o_stop_valid, o_cmd_err;
    logic [2:0]         o_state;
    logic [1:0]         o_stop_cause;
    logic [N_BP-1:0]    o_bp_en;
    logic [NB_STEP-1:0] o_cycles;

    du_exec_ctrl #(.NB_PC(NB_PC), .N_BP(N_BP), .NB_STEP(NB_STEP), .RST_CYC(RST_CYC)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_op(i_cmd_op), .i_cmd_idx(i_cmd_idx), .i_cmd_arg(i_cmd_arg), .i_halt(i_halt),
        .i_pc(i_pc), .o_clk_en(o_clk_en), .o_mips_reset(o_mips_reset), .o_state(o_state),
        .o_stop_cause(o_stop_cause), .o_stop_valid(o_stop_valid), .o_cmd_err(o_cmd_err),
        .o_bp_en(o_bp_en), .o_cycles(o_cycles)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic       is_err;
        logic [1:0] cause;
        logic [2:0] state;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_vec = 0, n_err = 0, en_cnt = 0, rst_seen = 0, n_stop = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void push_exp(input logic e, input logic [1:0] c, input logic [2:0] s);
        exp_q.push_back({e, c, s});
    endfunction

    always @(negedge i_clk) begin
        if (o_clk_en)     en_cnt++;
        if (o_mips_reset) rst_seen++;
        if (o_stop_valid) begin
            n_stop++;
            if (exp_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_stop: cause %0d state %0d, none expected", o_stop_cause, o_state);
            end else begin
                mon_e = exp_q.pop_front();
                check("stop_event", 32'({1'b0, o_stop_cause, o_state}), 32'(mon_e));
            end
        end
        if (o_cmd_err) begin
            if (exp_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_cmd_err: state %0d, none expected", o_state);
            end else begin
                mon_e = exp_q.pop_front();
                check("cmd_err_event", 32'({1'b1, o_state}), 32'({mon_e.is_err, mon_e.state}));
            end
        end
    end

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic [NB_IDX-1:0] idx, input logic [31:0] arg);
        i_cmd_valid = 1'b1; i_cmd_op = op; i_cmd_idx = idx; i_cmd_arg = arg;
        cyc();
        i_cmd_valid = 1'b0; i_cmd_op = 3'd0;
    endtask

    task automatic wait_leave(input logic [2:0] st, input int budget);
        int n = 0;
        while (o_state == st && n < budget) begin
            cyc();
            n++;
        end
        check("leave_state_within_budget", 32'(o_state != st), 1);
        cyc();
    endtask

    task automatic reset_vals(input string tag);
        check({tag, "_state"},      32'(o_state), 0);
        check({tag, "_clk_en"},     32'(o_clk_en), 0);
        check({tag, "_mips_reset"}, 32'(o_mips_reset), 0);
        check({tag, "_cause"},      32'(o_stop_cause), 0);
        check({tag, "_stop_valid"}, 32'(o_stop_valid), 0);
        check({tag, "_cmd_err"},    32'(o_cmd_err), 0);
        check({tag, "_bp_en"},      32'(o_bp_en), 0);
        check({tag, "_cycles"},     32'(o_cycles), 0);
        check({tag, "_cmd_ready"},  32'(o_cmd_ready), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, s0, r0;
        logic en;
        i_reset = 1'b1; i_cmd_valid = 1'b0; i_cmd_op = 3'd0; i_cmd_idx = '0;
        i_cmd_arg = '0; i_halt = 1'b0; i_pc = '0;
        cyc(); cyc();
        reset_vals("por");
        i_reset = 1'b0;
        cyc();

        // STEP 3: three enabled cycles, step-done stop
        base = en_cnt; s0 = n_stop;
        push_exp(1'b0, 2'd1, 3'd0);
        send(3'd2, 0, 32'd3);
        wait_leave(3'd2, 20);
        check("step3_en_cycles", 32'(en_cnt - base), 3);
        check("step3_cycles", 32'(o_cycles), 3);
        check("step3_cause", 32'(o_stop_cause), 1);
        check("step3_stop_pulses", 32'(n_stop - s0), 1);

        // breakpoint at 0x20 with PC advancing 4 per enabled cycle
        send(3'd4, 1, 32'h20);
        check("setbp1_en", 32'(o_bp_en), 32'b00010);
        i_pc = 32'h0; base = en_cnt;
        push_exp(1'b0, 2'd2, 3'd0);
        send(3'd1, 0, 0);
        for (int n = 0; n < 40 && o_state == 3'd1; n++) begin
            @(negedge i_clk);
            en = o_clk_en;
            if (i_pc == 32'h20) check("bp_gates_clk_en", 32'(en), 0);
            @(posedge i_clk);
            #1;
            if (en) i_pc = i_pc + 32'd4;
        end
        check("run_left", 32'(o_state != 3'd1), 1);
        cyc();
        check("bp_stop_pc", i_pc, 32'h20);
        check("bp_run_en_cycles", 32'(en_cnt - base), 8);
        check("bp_cause", 32'(o_stop_cause), 2);
        check("bp_cycles", 32'(o_cycles), 11);

        // resume with PC parked on the breakpoint: one enabled cycle, then re-stop
        base = en_cnt;
        push_exp(1'b0, 2'd2, 3'd0);
        send(3'd1, 0, 0);
        wait_leave(3'd1, 10);
        check("resume_en_cycles", 32'(en_cnt - base), 1);
        check("resume_cycles", 32'(o_cycles), 12);

        // breakpoint and PAUSE in the same cycle: breakpoint wins
        base = en_cnt;
        push_exp(1'b0, 2'd2, 3'd0);
        send(3'd1, 0, 0);
        cyc();
        send(3'd3, 0, 0);
        cyc();
        check("bp_vs_pause_en", 32'(en_cnt - base), 1);
        check("bp_vs_pause_cause", 32'(o_stop_cause), 2);

        // halt and breakpoint in the same cycle: halt wins, DONE
        base = en_cnt;
        push_exp(1'b0, 2'd3, 3'd3);
        send(3'd1, 0, 0);
        cyc();
        i_halt = 1'b1;
        #1;
        check("halt_gates_clk_en", 32'(o_clk_en), 0);
        cyc();
        i_halt = 1'b0;
        cyc();
        check("halt_state", 32'(o_state), 3);
        check("halt_cause", 32'(o_stop_cause), 3);
        check("halt_en_cycles", 32'(en_cnt - base), 1);
        check("halt_cycles", 32'(o_cycles), 14);

        // illegal commands in DONE
        push_exp(1'b1, 2'd0, 3'd3);
        send(3'd1, 0, 0);
        cyc();
        push_exp(1'b1, 2'd0, 3'd3);
        send(3'd3, 0, 0);
        cyc();
        check("done_stays", 32'(o_state), 3);

        // RESET_CPU: 4 reset cycles, clock held off, counters cleared, bps kept
        r0 = rst_seen; base = en_cnt;
        send(3'd6, 0, 0);
        check("reset_not_ready", 32'(o_cmd_ready), 0);
        wait_leave(3'd4, 10);
        check("reset_len", 32'(rst_seen - r0), 4);
        check("reset_no_clk_en", 32'(en_cnt - base), 0);
        check("reset_to_idle", 32'(o_state), 0);
        check("reset_cycles", 32'(o_cycles), 0);
        check("reset_keeps_bp", 32'(o_bp_en), 32'b00010);
        check("reset_released", 32'(o_mips_reset), 0);

        // STEP 10 paused on its 4th enabled cycle
        i_pc = 32'h100; base = en_cnt;
        push_exp(1'b0, 2'd0, 3'd0);
        send(3'd2, 0, 32'd10);
        cyc(); cyc(); cyc();
        send(3'd3, 0, 0);
        cyc();
        check("pause_en_cycles", 32'(en_cnt - base), 4);
        check("pause_cycles", 32'(o_cycles), 4);
        check("pause_state", 32'(o_state), 0);
        check("pause_cause", 32'(o_stop_cause), 0);

        // STEP 0 behaves as STEP 1
        base = en_cnt;
        push_exp(1'b0, 2'd1, 3'd0);
        send(3'd2, 0, 32'd0);
        wait_leave(3'd2, 10);
        check("step0_en_cycles", 32'(en_cnt - base), 1);
        check("step0_cycles", 32'(o_cycles), 5);

        // breakpoint table management and out-of-range indices
        push_exp(1'b1, 2'd0, 3'd0);
        send(3'd4, 3'd5, 32'h99);
        cyc();
        check("bad_set_no_change", 32'(o_bp_en), 32'b00010);
        push_exp(1'b1, 2'd0, 3'd0);
        send(3'd5, 3'd7, 0);
        cyc();
        check("bad_clr_no_change", 32'(o_bp_en), 32'b00010);
        send(3'd4, 3'd4, 32'h100);
        check("set_bp4", 32'(o_bp_en), 32'b10010);
        send(3'd5, 3'd1, 0);
        check("clr_bp1", 32'(o_bp_en), 32'b10000);
        send(3'd7, 0, 0);
        check("clr_all", 32'(o_bp_en), 0);
        send(3'd0, 0, 0);
        cyc();
        check("nop_state", 32'(o_state), 0);

        // illegal commands in RUN, then synchronous reset mid-run
        send(3'd4, 0, 32'h40);
        check("set_bp0", 32'(o_bp_en), 32'b00001);
        i_pc = 32'h20;
        send(3'd1, 0, 0);
        cyc();
        push_exp(1'b1, 2'd0, 3'd1);
        send(3'd1, 0, 0);
        check("run_err_stays", 32'(o_state), 1);
        push_exp(1'b1, 2'd0, 3'd1);
        send(3'd2, 0, 32'd2);
        cyc();
        check("run_step_err_stays", 32'(o_state), 1);
        i_reset = 1'b1;
        cyc();
        reset_vals("run_rst");
        i_reset = 1'b0;
        cyc();

        // synchronous reset during RESET_CPU
        send(3'd6, 0, 0);
        cyc();
        i_reset = 1'b1;
        cyc();
        reset_vals("rst_rst");
        i_reset = 1'b0;
        cyc(); cyc();

        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
